// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter (bin2bcd_seq) and its per-digit correction cell (bcd_add3).
//   state_t      converter FSM state encoding
//   bcd_digit_t  one packed BCD digit
//   ADD3_THRESH  digit value at or above which the double-dabble +3 applies
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, purely combinational.
// A digit of 5 or more becomes >= 10 after the following left shift, so
// adding 3 beforehand makes the shift carry into the next digit correctly.
// Ports:
//   digit      in   4   BCD digit before correction
//   digit_adj  out  4   digit + 3 when digit >= 5, otherwise digit
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t digit_adj
);

  assign digit_adj = (digit >= ADD3_THRESH) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter placed after
// the ALU; feeds packed BCD digits to the seven-segment display driver.
// One shift-and-correct iteration per clock, start/busy/done handshake.
//
// Parameters:
//   IN_W    width of the binary input (ALU result width), default 10
//   DIGITS  number of BCD digits on bcd_out, default 4
// Ports:
//   clk       in   1         clock, all logic on its rising edge
//   rst       in   1         synchronous active-high reset
//   start     in   1         conversion request, only sampled in IDLE
//   bin_in    in   IN_W      value captured on the edge that accepts start
//   busy      out  1         high while in CONV or FINISH
//   done      out  1         one-cycle pulse, bcd_out/overflow/neg valid from it
//   bcd_out   out  4*DIGITS  packed BCD, digit 0 in [3:0], held until next result
//   overflow  out  1         value did not fit in DIGITS digits
//   neg       out  1         sign of the input (signed build only, else 0)
//
// Build option: define BIN2BCD_SIGNED_EN to treat bin_in as two's complement;
// the magnitude is converted and the sign is reported on neg. Without it,
// bin_in is unsigned and neg is tied to 0.
//
// Timing: start accepted at edge 0, IN_W iterations on edges 1..IN_W, the
// FINISH state publishes the result on edge IN_W+1, so done is high in the
// cycle after that edge and the next start can be accepted on edge IN_W+2.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  neg
);

  // Scratch keeps one digit beyond the output so overflow can be detected.
  localparam int SW    = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  state_t              state_reg, state_next;
  logic [IN_W-1:0]     shreg_reg;
  logic [SW-1:0]       scratch_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic                done_reg;
  logic                overflow_reg;

  logic [SW-1:0]       scratch_adj;
  logic [SW+IN_W-1:0]  shift_word;
  logic [IN_W-1:0]     load_mag;

  // Per-digit +3 correction ahead of the shift.
  generate
    for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .digit     (scratch_reg[4*gi +: 4]),
        .digit_adj (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // {scratch, shreg} shifted left by one: the shreg MSB enters digit 0.
  assign shift_word = {scratch_adj, shreg_reg} << 1;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_reg;
  logic neg_reg;
  // Two's-complement magnitude; the most negative value maps to 2^(IN_W-1),
  // which still fits IN_W bits when read as unsigned.
  assign load_mag = bin_in[IN_W-1] ? (~bin_in + IN_W'(1)) : bin_in;
  assign neg      = neg_reg;
`else
  assign load_mag = bin_in;
  assign neg      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt_reg == CNT_LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      bcd_reg      <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_reg     <= 1'b0;
      neg_reg      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg   <= load_mag;
            scratch_reg <= '0;
            cnt_reg     <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_reg    <= bin_in[IN_W-1];
`endif
          end
        end
        CONV: begin
          scratch_reg <= shift_word[SW+IN_W-1:IN_W];
          shreg_reg   <= shift_word[IN_W-1:0];
          cnt_reg     <= cnt_reg + CNT_W'(1);
        end
        FINISH: begin
          bcd_reg      <= scratch_reg[4*DIGITS-1:0];
          overflow_reg <= |scratch_reg[SW-1 -: 4];
          done_reg     <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
          neg_reg      <= sign_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == CONV) || (state_reg == FINISH);
  assign done     = done_reg;
  assign bcd_out  = bcd_reg;
  assign overflow = overflow_reg;

endmodule
